// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end. It sums a programmed number of signed
// products and returns the total, with a sticky overflow flag, over a valid/ready handshake.
module product_accumulator #(
    parameter int PROD_W = 24,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              busy,
    output logic              sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic              sat_reg, sat_next;
    logic              out_valid_reg, out_valid_next;
    logic              busy_reg, busy_next;
    logic [LEN_W-1:0]  count_reg, count_next;
    logic [LEN_W-1:0]  len_reg, len_next;

    logic [ACC_W:0]    sum_wide;
    logic              sum_ovf;
    logic [ACC_W-1:0]  sum_clamped;
    logic [LEN_W-1:0]  count_plus;

    // One guard bit is enough: the top two bits disagree exactly when the sum has left the ACC_W range.
    always_comb begin
        sum_wide    = {acc_reg[ACC_W-1], acc_reg}
                    + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
        sum_ovf     = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        sum_clamped = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                              : sum_wide[ACC_W-1:0];
        count_plus  = count_reg + LEN_W'(1);
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        count_next = count_reg;
        len_next   = len_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    count_next = '0;
                    len_next   = len;
                    state_next = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    acc_next   = sum_clamped;
                    sat_next   = sat_reg | sum_ovf;
                    count_next = count_plus;
                    if (count_plus == len_reg) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        out_valid_next = (state_next == S_DONE);
        busy_next      = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            count_reg     <= '0;
            len_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            sat_reg       <= sat_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            count_reg     <= count_next;
            len_reg       <= len_next;
        end
    end

    assign acc_out   = acc_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 32-bit and a 25-bit accumulator share one stimulus stream
// and are compared every cycle against a transaction-level integer model.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [23:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [31:0] acc32;
    logic        ov32, busy32, sat32;
    logic [24:0] acc25;
    logic        ov25, busy25, sat25;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    product_accumulator #(.PROD_W(24), .ACC_W(32), .LEN_W(8)) dut32 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .out_ready(out_ready), .acc_out(acc32),
        .out_valid(ov32), .busy(busy32), .sat(sat32)
    );

    product_accumulator #(.PROD_W(24), .ACC_W(25), .LEN_W(8)) dut25 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .out_ready(out_ready), .acc_out(acc25),
        .out_valid(ov25), .busy(busy25), .sat(sat25)
    );

    always #5 clk = ~clk;

    // Model: 0 = waiting for start, 1 = collecting products, 2 = holding result.
    int     m_phase = 0;
    int     m_left  = 0;
    longint m_acc32 = 0;
    longint m_acc25 = 0;
    bit     m_sat32 = 1'b0;
    bit     m_sat25 = 1'b0;

    function automatic longint clamp_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint clamp_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    always @(posedge clk) begin
        longint p, r;
        if (rst) begin
            m_phase = 0; m_left = 0;
            m_acc32 = 0; m_acc25 = 0; m_sat32 = 1'b0; m_sat25 = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_acc32 = 0; m_acc25 = 0; m_sat32 = 1'b0; m_sat25 = 1'b0;
                m_left  = int'(len);
                m_phase = (len == 8'd0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (prod_valid) begin
                p = longint'($signed(prod_in));
                r = m_acc32 + p;
                if (r > clamp_max(32)) begin r = clamp_max(32); m_sat32 = 1'b1; end
                if (r < clamp_min(32)) begin r = clamp_min(32); m_sat32 = 1'b1; end
                m_acc32 = r;
                r = m_acc25 + p;
                if (r > clamp_max(25)) begin r = clamp_max(25); m_sat25 = 1'b1; end
                if (r < clamp_min(25)) begin r = clamp_min(25); m_sat25 = 1'b1; end
                m_acc25 = r;
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            if (out_ready) m_phase = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m32.acc_out",   64'(acc32),  64'(m_acc32[31:0]));
            check("m32.out_valid", 64'(ov32),   64'(m_phase == 2));
            check("m32.busy",      64'(busy32), 64'(m_phase != 0));
            check("m32.sat",       64'(sat32),  64'(m_sat32));
            check("m25.acc_out",   64'(acc25),  64'(m_acc25[24:0]));
            check("m25.out_valid", 64'(ov25),   64'(m_phase == 2));
            check("m25.busy",      64'(busy25), 64'(m_phase != 0));
            check("m25.sat",       64'(sat25),  64'(m_sat25));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1; len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [23:0] p, input int gap);
        for (int g = 0; g < gap; g++) tick();
        prod_in = p; prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [23:0] basic [4];

    initial begin
        basic[0] = 24'h000064; basic[1] = 24'hFFFFF1;
        basic[2] = 24'h3FF001; basic[3] = 24'hC00800;

        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset.acc_out", 64'(acc32), 64'd0);
        check("reset.out_valid", 64'(ov32), 64'd0);
        check("reset.busy", 64'(busy32), 64'd0);
        check("reset.sat", 64'(sat32), 64'd0);

        // Back-to-back products.
        do_start(8'd4);
        for (int i = 0; i < 4; i++) send(basic[i], 0);
        check("basic.out_valid", 64'(ov32), 64'd1);
        check("basic.acc_out", 64'(acc32), 64'hFFFFF856);
        check("basic.sat", 64'(sat32), 64'd0);
        drain();

        // Same products separated by bubbles.
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            send(basic[i], 1 + i % 3);
            if (i < 3) check("bubble.early_valid", 64'(ov32), 64'd0);
        end
        check("bubble.acc_out", 64'(acc32), 64'hFFFFF856);

        // Hold the result while start and stray products are presented.
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd3; prod_valid = i[0]; prod_in = 24'h123456;
            tick();
            check("hold.out_valid", 64'(ov32), 64'd1);
            check("hold.acc_out", 64'(acc32), 64'hFFFFF856);
            check("hold.busy", 64'(busy32), 64'd1);
            check("hold.sat", 64'(sat32), 64'd0);
        end
        prod_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("hold.release_valid", 64'(ov32), 64'd0);
        check("hold.release_busy", 64'(busy32), 64'd0);

        // Positive saturation on the 25-bit accumulator.
        do_start(8'd5);
        for (int i = 0; i < 5; i++) begin
            send(24'h400000, 0);
            if (i == 2) check("satpos.sat_before", 64'(sat25), 64'd0);
            if (i == 3) check("satpos.sat_4th", 64'(sat25), 64'd1);
        end
        check("satpos.acc_out", 64'(acc25), 64'h0FFFFFF);
        check("satpos.sat", 64'(sat25), 64'd1);
        check("satpos.acc32", 64'(acc32), 64'h01400000);
        tick();
        check("satpos.held", 64'(acc25), 64'h0FFFFFF);
        drain();

        // Negative saturation.
        do_start(8'd6);
        for (int i = 0; i < 6; i++) send(24'hC00000, 0);
        check("satneg.acc_out", 64'(acc25), 64'h1000000);
        check("satneg.sat", 64'(sat25), 64'd1);
        drain();

        // Zero-length request.
        do_start(8'd0);
        check("zero.out_valid", 64'(ov32), 64'd1);
        check("zero.acc_out", 64'(acc32), 64'd0);
        check("zero.sat", 64'(sat25), 64'd0);
        drain();

        // Reset in the middle of an operation.
        do_start(8'd4);
        send(basic[0], 0);
        send(basic[1], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.acc_out", 64'(acc32), 64'd0);
        check("midrst.out_valid", 64'(ov32), 64'd0);
        check("midrst.busy", 64'(busy32), 64'd0);
        check("midrst.sat", 64'(sat32), 64'd0);
        do_start(8'd1);
        send(24'h000005, 0);
        check("midrst.new_acc", 64'(acc32), 64'd5);
        check("midrst.new_valid", 64'(ov32), 64'd1);
        drain();

        // Random traffic checked only by the per-cycle model comparison.
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            start      = ($urandom_range(0, 9) == 0);
            len        = 8'($urandom_range(0, 6));
            prod_valid = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       prod_in = 24'h400000;
                1:       prod_in = 24'hC00000;
                2:       prod_in = 24'($urandom);
                default: prod_in = 24'($urandom_range(0, 255));
            endcase
            out_ready  = ($urandom_range(0, 9) < 3);
            tick();
        end
        rst = 1'b0; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sits directly downstream of the registered 12x12 signed multiplier.
- Consumes its 24-bit two's-complement product stream and sums a programmed number of products (dot-product / MAC) into a wider, saturating accumulator.
- Presents the final sum through a valid/ready output handshake.
- Raises a sticky saturation flag for the operation if any accumulation overflowed.

Parameters:
- PROD_W, 24, width of signed product input (matches multiplier Result).
- ACC_W, 32, width of signed accumulator/output; must be >= PROD_W.
- LEN_W, 8, width of the length field; max products per operation = 2^LEN_W - 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset: synchronous and active-high.
- start  input  1  request a new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of products to accumulate; sampled with start.
- prod_in  input  PROD_W  signed product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- out_ready  input  1  consumer accepts acc_out.
- acc_out  output  ACC_W  signed accumulated result.
- out_valid  output  1  acc_out holds a completed result.
- busy  output  1  high in ACCUM and DONE.
- sat  output  1  sticky: saturation occurred during the current or last operation.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: acc_out=0, out_valid=0, busy=0, sat=0, count=0, state=IDLE. A reset mid-operation abandons the operation with no partial result delivered.
- States: IDLE, ACCUM, DONE. All outputs are registered.
- IDLE:
  - prod_valid is ignored.
  - start=1 with len!=0: acc<=0, sat<=0, count<=0, latch len, go to ACCUM.
  - start=1 with len==0: acc<=0, sat<=0, go directly to DONE (zero-length result = 0).
- ACCUM:
  - In each cycle with prod_valid=1: acc <= sat_add(acc, sign_extend(prod_in)), and count increments.
  - Cycles with prod_valid=0 leave acc and count unchanged (bubbles are allowed, no timeout).
  - When the accepted product is number len (count==len-1 before the increment), the next state is DONE.
  - start is ignored.
- DONE:
  - out_valid=1; acc_out and sat are held stable until the handshake.
  - out_valid rises in the cycle after the final product is accepted, giving a latency of 1 clk from the last valid product.
  - out_ready=1 completes the transfer; the next state is IDLE and out_valid=0 in the following cycle.
  - start is ignored in DONE, including when it coincides with out_ready; it must be re-asserted in IDLE.
  - prod_valid is ignored.
- acc_out:
  - Updates with every accepted product (a running sum visible while in ACCUM).
  - Only meaningful when out_valid=1.
  - Retains its value in IDLE until the next start clears it.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value and set sat.
  - If the result is below -2^(ACC_W-1), clamp to that value and set sat.
  - After saturation, accumulation continues from the clamped value; there is no wrap-around.
- sat is cleared only by start accepted in IDLE, or by rst.
- busy = (state != IDLE).

Test Plan:
- Basic sum: rst 2 cycles, then start with len=4 and products 24'h000064, 24'hFFFFF1, 24'h3FF001, 24'hC00800 on 4 consecutive cycles.
  - Expected: out_valid=1 one cycle after the 4th product, acc_out=32'hFFFFF856 (-1962), sat=0.
- Bubbles:
  - Stimulus: same 4 products with prod_valid low for 1-3 cycles between them.
  - Expected: identical result 32'hFFFFF856; out_valid never rises before the 4th product.
- Saturation:
  - Stimulus: ACC_W=25, len=5, every prod_in=24'h400000.
  - Expected: acc_out=25'h0FFFFFF, sat=1 from the 4th product onward, held in DONE.
  - Follow-up: negative case with 6×(-4194304) and ACC_W=25 gives acc_out=25'h1000000, sat=1.
- Handshake hold:
  - Stimulus: result reached with out_ready=0 for 5 cycles, plus start and stray prod_valid pulses during that time.
  - Expected: out_valid, acc_out and sat stay stable and busy=1; on out_ready=1, IDLE is reached the next cycle with out_valid=0.
- Zero length: start with len=0.
  - Expected: out_valid=1 the next cycle, acc_out=0, sat=0.
- Reset mid-operation:
  - Stimulus: rst=1 after 2 of 4 products.
  - Expected: next cycle acc_out=0, out_valid=0, busy=0, sat=0. A new start with len=1 and prod 24'h000005 gives acc_out=5.
